inst_sram_resp: RTL and testbench

Instruction-SRAM responder: the memory-side end of the `inst_sram_*` interface driven by the fetch stage. It accepts one request per cycle and returns read data exactly one cycle after `inst_sram_en`, holding `inst_sram_rdata` stable while the requester stalls. It also supports byte-masked writes, a side-band preload port for bench/boot images, and out-of-window error reporting. It sits between the CPU core's fetch port and the SoC (or testbench) and replaces a vendor BRAM with a fully specified, verifiable model.

---
 rtl/inst_sram_resp.sv | 111 +++++++++++
 tb/tb_inst_sram_resp.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/inst_sram_resp.sv
// Instruction-SRAM responder: one request per cycle, registered read data held
// while idle, byte-masked write-first writes, side-band preload and window errors.
module inst_sram_resp #(
    parameter int unsigned ADDR_BITS = 12,
    parameter logic [31:0] BASE_ADDR = 32'h1c000000,
    parameter logic [31:0] ERR_DATA  = 32'h03400000
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 inst_sram_en,
    input  logic [3:0]           inst_sram_we,
    input  logic [31:0]          inst_sram_addr,
    input  logic [31:0]          inst_sram_wdata,
    output logic [31:0]          inst_sram_rdata,
    input  logic                 load_en,
    input  logic [ADDR_BITS-1:0] load_idx,
    input  logic [31:0]          load_data,
    output logic                 acc_err,
    output logic [7:0]           err_cnt
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_BITS;

    logic [31:0]          mem_r [DEPTH];
    logic [31:0]          rdata_r;
    logic                 acc_err_r;
    logic [7:0]           err_cnt_r;

    logic [31:0]          offset_s;
    logic [ADDR_BITS-1:0] idx_s;
    logic                 err_s;
    logic                 wr_s;
    logic                 load_hit_s;
    logic [31:0]          merged_s;
    logic [31:0]          resp_s;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] result;
        result = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                result[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                result[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return result;
    endfunction

    // Decode the request and pick the response word; a same-index preload overrides it.
    always_comb begin
        offset_s   = inst_sram_addr - BASE_ADDR;
        idx_s      = offset_s[ADDR_BITS+1:2];
        err_s      = 1'b0;
        wr_s       = 1'b0;
        load_hit_s = load_en && (load_idx == idx_s);
        merged_s   = merge_bytes(mem_r[idx_s], inst_sram_wdata, inst_sram_we);
        resp_s     = rdata_r;
        // Low offset bits equal the address's, since the base is word aligned.
        if (inst_sram_en) begin
            if ((offset_s[1:0] != 2'b00) || (offset_s[31:ADDR_BITS+2] != '0)) begin
                err_s  = 1'b1;
                resp_s = ERR_DATA;
            end else if (load_hit_s) begin
                wr_s   = (inst_sram_we != 4'b0000);
                resp_s = load_data;
            end else if (inst_sram_we != 4'b0000) begin
                wr_s   = 1'b1;
                resp_s = merged_s;
            end else begin
                resp_s = mem_r[idx_s];
            end
        end else begin
            resp_s = rdata_r;
        end
    end

    // Memory array: not cleared by reset; the preload is written last so it wins a collision.
    always_ff @(posedge clk) begin
        if (resetn) begin
            if (wr_s) begin
                mem_r[idx_s] <= merged_s;
            end
            if (load_en) begin
                mem_r[load_idx] <= load_data;
            end
        end
    end

    // Response, error pulse and saturating error counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_r   <= 32'h0000_0000;
            acc_err_r <= 1'b0;
            err_cnt_r <= 8'h00;
        end else begin
            rdata_r   <= resp_s;
            acc_err_r <= err_s;
            if (err_s && (err_cnt_r != 8'hff)) begin
                err_cnt_r <= err_cnt_r + 8'd1;
            end
        end
    end

    assign inst_sram_rdata = rdata_r;
    assign acc_err         = acc_err_r;
    assign err_cnt         = err_cnt_r;

endmodule

// File: tb/tb_inst_sram_resp.sv
// Directed bench for inst_sram_resp: inputs change and outputs are sampled on the falling edge.
module tb_inst_sram_resp;

    logic        clk;
    logic        resetn;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        load_en;
    logic [11:0] load_idx;
    logic [31:0] load_data;
    logic        acc_err;
    logic [7:0]  err_cnt;

    int vectors;
    int miscompares;

    inst_sram_resp #(
        .ADDR_BITS(12),
        .BASE_ADDR(32'h1c000000),
        .ERR_DATA (32'h03400000)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .inst_sram_en   (inst_sram_en),
        .inst_sram_we   (inst_sram_we),
        .inst_sram_addr (inst_sram_addr),
        .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_rdata(inst_sram_rdata),
        .load_en        (load_en),
        .load_idx       (load_idx),
        .load_data      (load_data),
        .acc_err        (acc_err),
        .err_cnt        (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        resetn = 1'b0;
        inst_sram_en = 1'b0; inst_sram_we = 4'h0; inst_sram_addr = 32'h0; inst_sram_wdata = 32'h0;
        load_en = 1'b0; load_idx = 12'h0; load_data = 32'h0;
        #1;
        vectors++; if (inst_sram_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata got %h want %h", inst_sram_rdata, 32'h0); end
        vectors++; if (acc_err !== 1'b0) begin miscompares++; $display("FAIL reset_acc_err got %b want 0", acc_err); end
        vectors++; if (err_cnt !== 8'h00) begin miscompares++; $display("FAIL reset_err_cnt got %h want 00", err_cnt); end
        @(negedge clk); @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_preload_read();
        load_en = 1'b1; load_idx = 12'd0; load_data = 32'h02800421;
        @(negedge clk);
        load_idx = 12'd1; load_data = 32'h1c000000;
        @(negedge clk);
        load_en = 1'b0; inst_sram_en = 1'b1; inst_sram_we = 4'h0; inst_sram_addr = 32'h1c000000;
        #1;
        vectors++; if (inst_sram_rdata !== 32'h0) begin miscompares++; $display("FAIL read0_not_early got %h want %h", inst_sram_rdata, 32'h0); end
        @(negedge clk);
        vectors++; if (inst_sram_rdata !== 32'h02800421) begin miscompares++; $display("FAIL read0 got %h want %h", inst_sram_rdata, 32'h02800421); end
        inst_sram_addr = 32'h1c000004;
        @(negedge clk);
        vectors++; if (inst_sram_rdata !== 32'h1c000000) begin miscompares++; $display("FAIL read1 got %h want %h", inst_sram_rdata, 32'h1c000000); end
        vectors++; if (acc_err !== 1'b0) begin miscompares++; $display("FAIL read1_acc_err got %b want 0", acc_err); end
        inst_sram_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_hold();
        inst_sram_en = 1'b1; inst_sram_we = 4'h0; inst_sram_addr = 32'h1c000000;
        @(negedge clk);
        inst_sram_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            inst_sram_addr = $urandom;
            inst_sram_we = 4'($urandom_range(0, 15));
            @(negedge clk);
            vectors++; if (inst_sram_rdata !== 32'h02800421) begin miscompares++; $display("FAIL hold_rdata[%0d] got %h want %h", i, inst_sram_rdata, 32'h02800421); end
            vectors++; if (acc_err !== 1'b0) begin miscompares++; $display("FAIL hold_acc_err[%0d] got %b want 0", i, acc_err); end
        end
        inst_sram_we = 4'h0;
    endtask

    task automatic test_byte_write();
        load_en = 1'b1; load_idx = 12'd2; load_data = 32'h11223344;
        @(negedge clk);
        load_en = 1'b0;
        inst_sram_en = 1'b1; inst_sram_we = 4'b0010; inst_sram_addr = 32'h1c000008; inst_sram_wdata = 32'hAABBCCDD;
        @(negedge clk);
        vectors++; if (inst_sram_rdata !== 32'h1122CC44) begin miscompares++; $display("FAIL write_first got %h want %h", inst_sram_rdata, 32'h1122CC44); end
        inst_sram_we = 4'h0;
        @(negedge clk);
        vectors++; if (inst_sram_rdata !== 32'h1122CC44) begin miscompares++; $display("FAIL write_readback got %h want %h", inst_sram_rdata, 32'h1122CC44); end
        inst_sram_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_errors();
        logic [31:0] err_addr [3];
        err_addr[0] = 32'h1bfffffc; err_addr[1] = 32'h1c000002; err_addr[2] = 32'h1c004000;
        load_en = 1'b1; load_idx = 12'hfff; load_data = 32'hCAFEF00D;
        @(negedge clk);
        load_en = 1'b0;
        inst_sram_en = 1'b1; inst_sram_we = 4'hf; inst_sram_wdata = 32'h55555555;
        for (int i = 0; i < 3; i++) begin
            inst_sram_addr = err_addr[i];
            @(negedge clk);
            vectors++; if (acc_err !== 1'b1) begin miscompares++; $display("FAIL err_pulse[%0d] got %b want 1", i, acc_err); end
            vectors++; if (inst_sram_rdata !== 32'h03400000) begin miscompares++; $display("FAIL err_rdata[%0d] got %h want %h", i, inst_sram_rdata, 32'h03400000); end
            vectors++; if (err_cnt !== 8'(i + 1)) begin miscompares++; $display("FAIL err_cnt[%0d] got %h want %h", i, err_cnt, 8'(i + 1)); end
        end
        inst_sram_we = 4'h0; inst_sram_addr = 32'h1c000000;
        @(negedge clk);
        vectors++; if (acc_err !== 1'b0) begin miscompares++; $display("FAIL err_drop got %b want 0", acc_err); end
        vectors++; if (inst_sram_rdata !== 32'h02800421) begin miscompares++; $display("FAIL err_mem_idx0 got %h want %h", inst_sram_rdata, 32'h02800421); end
        inst_sram_addr = 32'h1c003ffc;
        @(negedge clk);
        vectors++; if (inst_sram_rdata !== 32'hCAFEF00D) begin miscompares++; $display("FAIL err_mem_idxfff got %h want %h", inst_sram_rdata, 32'hCAFEF00D); end
        vectors++; if (err_cnt !== 8'd3) begin miscompares++; $display("FAIL err_cnt_hold got %h want 03", err_cnt); end
        inst_sram_addr = 32'h1c000001;
        repeat (297) @(negedge clk);
        vectors++; if (err_cnt !== 8'hff) begin miscompares++; $display("FAIL err_cnt_300 got %h want ff", err_cnt); end
        repeat (5) @(negedge clk);
        vectors++; if (err_cnt !== 8'hff) begin miscompares++; $display("FAIL err_cnt_sat got %h want ff", err_cnt); end
        inst_sram_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_same_cycle();
        load_en = 1'b1; load_idx = 12'd3; load_data = 32'h0;
        @(negedge clk);
        load_data = 32'hDEADBEEF;
        inst_sram_en = 1'b1; inst_sram_we = 4'h0; inst_sram_addr = 32'h1c00000c;
        @(negedge clk);
        vectors++; if (inst_sram_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL load_vs_read got %h want %h", inst_sram_rdata, 32'hDEADBEEF); end
        load_data = 32'h5; inst_sram_we = 4'hf; inst_sram_wdata = 32'h0;
        @(negedge clk);
        vectors++; if (inst_sram_rdata !== 32'h5) begin miscompares++; $display("FAIL load_vs_write got %h want %h", inst_sram_rdata, 32'h5); end
        load_en = 1'b0; inst_sram_we = 4'h0;
        @(negedge clk);
        vectors++; if (inst_sram_rdata !== 32'h5) begin miscompares++; $display("FAIL load_wins_mem got %h want %h", inst_sram_rdata, 32'h5); end
        load_en = 1'b1; load_idx = 12'd4; load_data = 32'h0BADF00D; inst_sram_addr = 32'h1c000000;
        @(negedge clk);
        vectors++; if (inst_sram_rdata !== 32'h02800421) begin miscompares++; $display("FAIL load_other_idx got %h want %h", inst_sram_rdata, 32'h02800421); end
        load_en = 1'b0; inst_sram_addr = 32'h1c000010;
        @(negedge clk);
        vectors++; if (inst_sram_rdata !== 32'h0BADF00D) begin miscompares++; $display("FAIL load_other_mem got %h want %h", inst_sram_rdata, 32'h0BADF00D); end
        inst_sram_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        inst_sram_en = 1'b1; inst_sram_we = 4'h0; inst_sram_addr = 32'h1c000000;
        @(negedge clk);
        inst_sram_addr = 32'h1c000004;
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        vectors++; if (inst_sram_rdata !== 32'h0) begin miscompares++; $display("FAIL async_rdata got %h want %h", inst_sram_rdata, 32'h0); end
        vectors++; if (err_cnt !== 8'h00) begin miscompares++; $display("FAIL async_err_cnt got %h want 00", err_cnt); end
        @(negedge clk);
        inst_sram_we = 4'hf; inst_sram_addr = 32'h1c000000; inst_sram_wdata = 32'hFFFFFFFF;
        load_en = 1'b1; load_idx = 12'd1; load_data = 32'h0;
        @(negedge clk);
        vectors++; if (inst_sram_rdata !== 32'h0) begin miscompares++; $display("FAIL in_reset_rdata got %h want %h", inst_sram_rdata, 32'h0); end
        resetn = 1'b1; load_en = 1'b0; inst_sram_we = 4'h0; inst_sram_addr = 32'h1c000000;
        @(negedge clk);
        vectors++; if (inst_sram_rdata !== 32'h02800421) begin miscompares++; $display("FAIL post_reset_idx0 got %h want %h", inst_sram_rdata, 32'h02800421); end
        vectors++; if (err_cnt !== 8'h00) begin miscompares++; $display("FAIL post_reset_err_cnt got %h want 00", err_cnt); end
        inst_sram_addr = 32'h1c000004;
        @(negedge clk);
        vectors++; if (inst_sram_rdata !== 32'h1c000000) begin miscompares++; $display("FAIL post_reset_idx1 got %h want %h", inst_sram_rdata, 32'h1c000000); end
        inst_sram_en = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_preload_read();
        test_hold();
        test_byte_write();
        test_errors();
        test_same_cycle();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
